// File: rtl/burst_pkg.sv
// Shared types and default sizes for the vertex RAM burst reader.
package burst_pkg;

  localparam int DEF_A_WIDTH    = 9;
  localparam int DEF_LEN_WIDTH  = 10;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/burst_fifo.sv
// Small skid FIFO with same-cycle bypass so a word returned by the RAM can be
// presented downstream in the cycle it arrives. RST flushes it synchronously.
module burst_fifo
  import burst_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  fifo_entry_t      push_entry,
  input  logic             pop,
  output logic             head_valid,
  output fifo_entry_t      head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             empty;
  logic             bypass;
  logic             do_write;
  logic             do_read;

  assign empty      = (count_q == '0);
  // An incoming word that is consumed in the same cycle never touches storage.
  assign bypass     = empty && push && pop;
  assign do_write   = push && !bypass;
  assign do_read    = pop && !empty;
  assign head_valid = !empty || push;
  assign count      = count_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head = '0;
    if (!empty)    head = mem[rd_ptr];
    else if (push) head = push_entry;
  end

  // NOTE: storage is not reset; occupancy lives in the pointers and count, so stale entries are never observed.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vertex_burst_reader.sv
// Burst read engine in front of the vertex RAM: (addr, len) command in, word stream out.
// Define BURST_CLEAR_EN to turn every read into a read-and-clear of the RAM slot.
module vertex_burst_reader
  import burst_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [A_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0] start_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 ram_en,
  output logic [3:0]           ram_we,
  output logic [31:0]          ram_di,
  output logic [A_WIDTH-1:0]   ram_a,
  input  logic [31:0]          ram_do
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t               state;
  logic [A_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0] remain_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 head_valid;
  fifo_entry_t          push_entry;
  fifo_entry_t          head;
  logic [CNT_W-1:0]     fifo_count;

  // Never let queued plus in-flight words exceed the FIFO, so a push always has room.
  assign issue = (state == RUN) &&
                 ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);

  assign start_ready = (state == IDLE) && !RST;
  assign busy        = (state != IDLE);
  assign ram_en      = issue;
  assign ram_a       = addr_q;
  assign ram_di      = '0;

`ifdef BURST_CLEAR_EN
  assign ram_we = issue ? 4'hF : 4'h0;
`else
  assign ram_we = 4'h0;
`endif

  assign push       = inflight_q && !RST;
  assign push_entry = '{last: inflight_last_q, data: ram_do};
  assign pop        = head_valid && out_ready;

  assign out_valid = head_valid;
  assign out_data  = head.data;
  assign out_last  = head.last;

  burst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == LEN_WIDTH'(1));
      case (state)
        IDLE: begin
          // Zero-length commands are consumed without leaving IDLE.
          if (start_valid && (start_len != '0)) begin
            addr_q   <= start_addr;
            remain_q <= start_len;
            state    <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q   <= addr_q + A_WIDTH'(1);
            remain_q <= remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_burst_reader.sv
// Scoreboard bench for vertex_burst_reader with a behavioural RAM and reference model.
// Honours BURST_CLEAR_EN when the design is built with it.
module tb_vertex_burst_reader;

  localparam int DEPTH = 2;
`ifdef BURST_CLEAR_EN
  localparam logic [3:0] EXP_WE = 4'hF;
`else
  localparam logic [3:0] EXP_WE = 4'h0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_valid;
  logic        start_ready;
  logic [8:0]  start_addr;
  logic [9:0]  start_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [8:0]  ram_a;
  logic [31:0] ram_do = '0;

  vertex_burst_reader dut (
    .CLK         (CLK),
    .RST         (RST),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_addr  (start_addr),
    .start_len   (start_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_di      (ram_di),
    .ram_a       (ram_a),
    .ram_do      (ram_do)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM environment: one-cycle read latency, read-before-write, zero when disabled.
  logic [31:0] tb_mem  [512];
  logic [31:0] ref_mem [512];

  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= tb_mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) tb_mem[ram_a][8*b +: 8] = ram_di[8*b +: 8];
    end else begin
      ram_do <= '0;
    end
  end

  typedef struct {
    logic        last;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [8:0] a;
    int         cyc;
  } aexp_t;

  exp_t  exp_q [$];
  aexp_t addr_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int issued   = 0;
  int popped   = 0;
  int pops_total = 0;
  int ready_mode = 0;
  bit mon_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      check("ram_write_drive", {ram_we, ram_di}, {(ram_en ? EXP_WE : 4'h0), 32'h0});
      if (ram_en) begin
        check("outstanding_le_depth", 64'((issued - popped) < DEPTH), 64'd1);
        if (addr_q.size() == 0) begin
          check("spurious_ram_en", ram_en, 1'b0);
        end else begin
          aexp_t ea;
          ea = addr_q.pop_front();
          check("ram_a", ram_a, ea.a);
          if (ea.cyc >= 0) check("ram_en_cycle", cyc, ea.cyc);
        end
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_last_data", {out_last, out_data}, {e.last, e.data});
          if (e.cyc >= 0) check("out_cycle", cyc, e.cyc);
        end
        popped++;
        pops_total++;
      end
    end
  end

  task automatic ready_driver();
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Issue one command; the reference model expands it into expected addresses and words.
  task automatic send_cmd(input int addr, input int len, input bit timed);
    int t;
    int waited = 0;
    start_addr  = addr[8:0];
    start_len   = len[9:0];
    start_valid = 1'b1;
    @(negedge CLK);
    while (!start_ready && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    check("cmd_accepted", start_ready, 1'b1);
    t = cyc;
    for (int k = 0; k < len; k++) begin
      int wa;
      aexp_t ea;
      exp_t  e;
      wa     = (addr + k) % 512;
      ea.a   = 9'(wa);
      ea.cyc = timed ? t + 1 + k : -1;
      e.last = (k == len - 1);
      e.data = ref_mem[wa];
      e.cyc  = timed ? t + 2 + k : -1;
      addr_q.push_back(ea);
      exp_q.push_back(e);
`ifdef BURST_CLEAR_EN
      ref_mem[wa] = '0;
`endif
    end
    @(posedge CLK);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) done = 1;
    end
    check("burst_complete_idle", done, 1'b1);
    @(posedge CLK);
    #1;
  endtask

  task automatic preload_a0();
    for (int i = 0; i < 4; i++) begin
      tb_mem[10 + i]  = 32'(32'hA0 + i);
      ref_mem[10 + i] = 32'(32'hA0 + i);
    end
  endtask

  initial begin
    int p0;
    RST = 1'b1;
    start_valid = 1'b0;
    start_addr = '0;
    start_len = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [31:0] v;
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    preload_a0();
    fork
      ready_driver();
    join_none

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_start_ready_low", start_ready, 1'b0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_start_ready_high", start_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ram_drive", {ram_en, ram_we, ram_di, ram_a}, '0);
    check("rst_out_data", out_data, 32'h0);
    mon_en = 1;
    @(posedge CLK);
    #1;

    // Preloaded words with full throughput and exact cycle timing.
    ready_mode = 0;
    send_cmd(10, 4, 1);
    wait_idle();
    check("busy_after_burst", busy, 1'b0);

    // Address wrap 510, 511, 0, 1.
    send_cmd(510, 4, 1);
    wait_idle();

    // 1010 backpressure on an 8-word burst.
    ready_mode = 1;
    send_cmd(int'($urandom_range(0, 511)), 8, 0);
    wait_idle();

    // Zero-length command: consumed, nothing issued or emitted.
    ready_mode = 0;
    send_cmd(100, 0, 0);
    repeat (3) begin
      @(negedge CLK);
      check("len0_no_ram_en", ram_en, 1'b0);
      check("len0_no_out_valid", out_valid, 1'b0);
      check("len0_idle", {busy, start_ready}, 2'b01);
    end
    @(posedge CLK);
    #1;

    // Random bursts under random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      send_cmd(int'($urandom_range(0, 511)), int'($urandom_range(1, 24)), 0);
      wait_idle();
    end

    // Full-memory burst covering the wrap.
    send_cmd(int'($urandom_range(0, 511)), 512, 0);
    wait_idle();

    // Reset in the middle of an 8-word burst.
    ready_mode = 0;
    p0 = pops_total;
    send_cmd(20, 8, 0);
    for (int i = 0; i < 100 && pops_total < p0 + 3; i++) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    popped = 0;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_start_ready", start_ready, 1'b1);
    check("midrst_ram_en", ram_en, 1'b0);
    @(posedge CLK);
    #1;
    send_cmd(40, 2, 1);
    wait_idle();

    // Read the same range twice; with read-and-clear the second pass is zeros.
    preload_a0();
    send_cmd(10, 4, 1);
    wait_idle();
    send_cmd(10, 4, 1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vertex_burst_reader.md
# vertex_burst_reader

Burst read engine sitting directly upstream of the 512x32 zero-initialised vertex RAM. It accepts a (base address, length) command, drives the RAM's single port to fetch consecutive words, absorbs the RAM's one-cycle read latency in a small skid FIFO, and presents the words downstream on a valid/ready stream with a last marker. A compile-time option turns each read into a read-and-clear, so consumed vertex slots return to zero.

## Interface
- `A_WIDTH`, 9: RAM address width; word count is 2**A_WIDTH.
- `LEN_WIDTH`, 10: command length width; carries 0..512.
- `FIFO_DEPTH`, 2: skid FIFO entries; minimum 2.
- Clock and reset: one clock, `CLK`; reset `RST` is synchronous and active-high.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: synchronous, active-high reset.
- `start_valid` in 1: command offered.
- `start_ready` out 1: command accepted when both valid and ready are high.
- `start_addr` in A_WIDTH: first word address.
- `start_len` in LEN_WIDTH: number of words to read.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out 32: RAM word.
- `out_last` out 1: final word of the burst; qualified by `out_valid`.
- `busy` out 1: high in RUN or DRAIN.
- `ram_en` out 1: drives the RAM's EN0.
- `ram_we` out 4: drives WE0.
- `ram_di` out 32: drives Di0.
- `ram_a` out A_WIDTH: drives A0.
- `ram_do` in 32: from Do0; valid in the cycle after `ram_en`.

## Operation
- State machine: IDLE, RUN, DRAIN.
- IDLE:
  - `start_ready` = 1.
  - Accepted command with `start_len` != 0: latch addr and len, go to RUN.
  - `start_len` == 0: command consumed, no output, stay in IDLE.
- RUN:
  - Issue a read (`ram_en`=1, `ram_a`=current addr) when FIFO occupancy + in-flight < FIFO_DEPTH.
  - Each issue increments addr modulo 2**A_WIDTH (511 wraps to 0) and decrements the remaining count.
  - The issue that brings the remaining count to 0 moves the FSM to DRAIN.
- DRAIN:
  - No issues.
  - When the last word has been popped (out_valid & out_ready & out_last), go to IDLE.
- In-flight flag:
  - Set on issue. Next cycle `ram_do` is pushed into the FIFO; the tag carries last = (final issue).
  - `ram_do` is ignored when no read is in flight; the RAM outputs zero when disabled.
- Outputs:
  - `out_valid` = FIFO non-empty; `out_data`/`out_last` come from the FIFO head.
  - Push and pop in the same cycle are legal.
- `start_ready` = 0 in RUN and DRAIN; no command queueing.
- Length 512 reads every word exactly once, including across the wrap.

## Timing
- Reset values: `start_ready`=0 while `RST` is high, then 1 (IDLE); `out_valid`, `out_last`, `busy`, `ram_en`=0; `ram_we`=0; `ram_di`=0; `ram_a`=0; `out_data`=0.
- `RST` mid-burst: the FSM goes to IDLE, the FIFO is flushed, and the in-flight read is discarded. No `out_valid` in the cycle after reset.
- Command accepted at cycle t: first `ram_en` at t+1, first `out_valid` at t+2.
- With `out_ready` held high: one word per cycle; an N-word burst's last word appears at t+N+1.
- DRAIN→IDLE on the cycle after the last pop; a new command can be accepted at the earliest one cycle later.
- Backpressure: `out_ready` low stalls issue within 2 cycles; no word is lost or duplicated.

## Configuration
- `BURST_CLEAR_EN` defined: every issue also writes `ram_we`=4'hF, `ram_di`=0. The RAM returns the old word (read-before-write), so the slot reads zero afterwards.
- `BURST_CLEAR_EN` undefined: `ram_we`=4'h0 and `ram_di`=0 always; pure read.

## Structure
- Package `burst_pkg`:
  - `A_WIDTH`, `LEN_WIDTH`, `FIFO_DEPTH` defaults.
  - FSM state enum (IDLE/RUN/DRAIN).
  - FIFO entry typedef {last, data[31:0]}.
- Sub-module `burst_fifo`: synchronous FIFO with push/pop, count output, sync flush on `RST`.

## Test plan
- Preload RAM[10..13] = 0xA0..0xA3; cmd addr 10, len 4, `out_ready`=1 → 0xA0..0xA3 on consecutive cycles starting t+2, `out_last` only on 0xA3, `busy` drops after.
- Cmd addr 510, len 4 → reads 510, 511, 0, 1 in order; `ram_a` wraps to 0.
- Toggle `out_ready` 1010…, len 8 → all 8 words in order, never more than 2 outstanding, no duplicates.
- Cmd len 0 → accepted in one cycle, no `ram_en`, no `out_valid`; cmd len 512 → 512 words, each address once.
- Assert `RST` after 3 words of an 8-word burst → next cycle: FIFO empty, IDLE, `start_ready` high; a new burst of len 2 runs cleanly.
- With `BURST_CLEAR_EN`: len 4 at addr 10 → data 0xA0..0xA3 out; re-read same range → four zeros.
